// File: rtl/keccak_pkg.sv
// Shared SHA-3 definitions: digest-size encodings, rate lookup, padding bytes.
// Used by the absorb padder, the permutation core and the AXI wrapper.
package keccak_pkg;

  localparam int RATE_MAX_BITS = 1152;

  // out_size / block_size encodings
  localparam logic [1:0] SHA3_512 = 2'b00;
  localparam logic [1:0] SHA3_384 = 2'b01;
  localparam logic [1:0] SHA3_256 = 2'b10;
  localparam logic [1:0] SHA3_224 = 2'b11;

  // SHA-3 domain separator + pad10*1 terminator
  localparam logic [7:0] PAD_START = 8'h06;
  localparam logic [7:0] PAD_END   = 8'h80;

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } padder_state_t;

  // Rate in bytes for a digest size.
  function automatic logic [7:0] rate_bytes(input logic [1:0] sz);
    case (sz)
      SHA3_512: rate_bytes = 8'd72;
      SHA3_384: rate_bytes = 8'd104;
      SHA3_256: rate_bytes = 8'd136;
      default:  rate_bytes = 8'd144;
    endcase
  endfunction

endpackage

// File: rtl/keccak_padder.sv
// Absorb-side front end: packs 32-bit message words into a rate-sized block,
// applies SHA-3 padding on the final word and hands blocks to the permutation
// core over valid/ready.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   clear             soft reset, identical effect to reset
//   out_size          digest size, sampled on the first word of a message
//   in_data/in_last/in_bytes/in_valid/in_ready   word input (MSB-first bytes)
//   block_data/size/first/last/valid/ready      block output to the core
module keccak_padder #(
  parameter int RATE_MAX_BITS = 1152,
  parameter int WORD_W        = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic [1:0]               out_size,
  input  logic [WORD_W-1:0]        in_data,
  input  logic                     in_last,
  input  logic [1:0]               in_bytes,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [RATE_MAX_BITS-1:0] block_data,
  output logic [1:0]               block_size,
  output logic                     block_first,
  output logic                     block_last,
  output logic                     block_valid,
  input  logic                     block_ready
);
  import keccak_pkg::*;

  localparam int NBYTES = RATE_MAX_BITS / 8;
  localparam int IW     = $clog2(NBYTES);
  localparam int CW     = $clog2(NBYTES / 4 + 1);

  padder_state_t             state, state_nxt;
  logic [CW-1:0]             word_cnt;
  logic                      first_flag;
  logic [NBYTES-1:0][7:0]    blk_buf, buf_nxt;

  logic                      accept, handshake, msg_start, word_full;
  logic [1:0]                cur_size;
  logic [7:0]                rate;
  logic [IW-1:0]             base, rate_last;
  logic [7:0]                lane;

  assign in_ready    = (state == FILL);
  assign block_valid = (state == EMIT);
  assign block_data  = blk_buf;
  // first_flag stays set until the first block of a message is taken
  assign block_first = block_valid && first_flag;

  assign accept    = in_valid && in_ready;
  assign handshake = block_valid && block_ready;

  // Rate follows out_size only on the opening word; afterwards the latched size
  assign msg_start = (word_cnt == '0) && first_flag;
  assign cur_size  = msg_start ? out_size : block_size;
  assign rate      = rate_bytes(cur_size);
  assign word_full = (word_cnt == CW'(rate >> 2) - CW'(1));
  assign rate_last = IW'(rate - 8'd1);
  assign base      = IW'({word_cnt, 2'b00});

  // Byte-lane write of the incoming word, with padding folded in on the
  // final word. The 0x80 is XORed so that a pad start landing on the last
  // rate byte yields 0x86.
  always_comb begin
    buf_nxt = blk_buf;
    lane    = '0;
    for (int j = 0; j < 4; j++) begin
      lane = in_data[WORD_W-1-8*j -: 8];
      if (in_last && (j >= int'(in_bytes))) lane = 8'h00;
      if (in_last && (j == int'(in_bytes))) lane = PAD_START;
      buf_nxt[base + IW'(j)] = lane;
    end
    if (in_last) buf_nxt[rate_last] = buf_nxt[rate_last] ^ PAD_END;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (accept && (in_last || word_full)) state_nxt = EMIT;
      EMIT:    if (block_ready) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state      <= FILL;
      word_cnt   <= '0;
      first_flag <= 1'b1;
      blk_buf    <= '0;
      block_size <= '0;
      block_last <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        blk_buf <= buf_nxt;
        if (msg_start) block_size <= out_size;
        if (in_last) block_last <= 1'b1;
        else         word_cnt   <= word_cnt + CW'(1);
      end
      if (handshake) begin
        blk_buf    <= '0;
        word_cnt   <= '0;
        first_flag <= block_last;
        block_last <= 1'b0;
      end
    end
  end

endmodule
